eth_mac_recv: RTL and testbench
===============================

# eth_mac_recv

Receive MAC stage directly downstream of the RGMII byte receiver. It consumes the SFD-stripped byte stream (`rx_data` and `rx_active`) in the same clock domain. It filters on destination address, extracts source MAC and ethertype, and forwards payload bytes with the 4-byte FCS removed. At end of frame it reports CRC32 and length status so downstream protocol logic can commit or discard the buffered payload.

## Interface
- `MIN_FRAME_LEN`, default 64: minimum legal length in bytes, counted from the first destination byte through the last FCS byte.
- `MAX_FRAME_LEN`, default 1518: maximum legal length in bytes, counted the same way.
- `clock`  in  1  rx byte clock, rising edge.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `local_mac`  in  48  own address, byte 0 in [47:40]; quasi-static.
- `broadcast_en`  in  1  also accept FF:FF:FF:FF:FF:FF.
- `rx_data`  in  8  frame byte; valid when `rx_active`=1.
- `rx_active`  in  1  high for every byte of the frame, from the first destination byte through the last FCS byte.
- `out_data`  out  8  payload byte.
- `out_valid`  out  1  `out_data` valid this cycle.
- `out_sop`  out  1  asserted with the first payload byte.
- `src_mac`  out  48  source address of the current frame.
- `ethertype`  out  16  type/length field, big-endian.
- `frame_done`  out  1  one-cycle end-of-frame strobe.
- `frame_ok`  out  1  status qualified by `frame_done`.
- `crc_err`  out  1  status qualified by `frame_done`.
- `len_err`  out  1  status qualified by `frame_done`.
- `payload_len`  out  11  number of bytes forwarded on `out_data`; qualified by `frame_done`.

## Operation
- **States and transitions:**
  - WAIT_IDLE entered on reset; go to IDLE when `rx_active` is sampled 0.
  - IDLE: on `rx_active`=1, go to DST.
  - DST (6 bytes), then SRC (6 bytes), then TYPE (2 bytes), then PAYLOAD.
  - DROP.
- **Byte counter:** `byte_cnt` (11 bits, saturating at 2047) counts every byte of the frame.
- **Address filter:** the compare is evaluated on the 6th byte.
  - Match means dst == `local_mac`, or `broadcast_en` and dst is all-ones.
  - No match: go to DROP. A filtered frame produces no `out_valid` and no `frame_done`.
- **Header fields:** `src_mac` and `ethertype` load as their bytes arrive. They are held stable from `out_sop` until the next frame's SRC state.
- **FCS strip:** payload bytes pass through a 4-deep shift register. Byte k is emitted only once byte k+4 has been received, so the final 4 bytes, which are the FCS, are never emitted.
- **CRC32:**
  - Reflected polynomial 0xEDB88320, init 0xFFFFFFFF, updated 8 bits per clock, LSB first.
  - Covers every byte from the first destination byte through the last FCS byte.
  - The frame is good when the register equals residue 0xDEBB20E3 after the last byte.
- **Length check:** when `byte_cnt` exceeds `MAX_FRAME_LEN`, set `len_err`, go to DROP and suppress further `out_valid`. `frame_done` still fires when `rx_active` falls.
- **End of frame:** the first edge that samples `rx_active`=0 after an accepted frame does the following.
  - Registers `frame_done`=1.
  - `crc_err` = residue mismatch.
  - `len_err` = `byte_cnt` < `MIN_FRAME_LEN` or > `MAX_FRAME_LEN`.
  - `frame_ok` = !`crc_err` & !`len_err`.
  - `payload_len` = number of `out_valid` cycles in this frame.
  - Moves to IDLE.
- **Early end:** a frame accepted by the filter that ends in SRC or TYPE reports `len_err`=1 with `payload_len`=0.
- **Back-to-back frames:** `rx_active` may rise again on the edge right after the end edge. IDLE accepts that byte as a new DST byte while `frame_done` for the previous frame is high.
- **Reset:** async reset mid-frame aborts the frame. After release, if `rx_active` is still 1, the block stays in WAIT_IDLE until `rx_active` is sampled 0. No partial frame is reported.

## Timing
- Reset values: every output is 0, including `src_mac`, `ethertype` and `payload_len`.
- Latency: the payload byte sampled at edge n appears on `out_data`/`out_valid` in the cycle after edge n+4.
- `out_sop` accompanies the first `out_valid` of the frame only.
- `out_valid` is continuous, with no gaps, within a frame. It cannot be throttled; there is no ready signal.
- The last FCS byte is sampled at edge m, and the last payload byte is shown in the cycle after m. `rx_active`=0 is sampled at m+1, and `frame_done` is high in the cycle after m+1, i.e. immediately following the last `out_valid` cycle.
- `frame_done` is exactly one cycle long. `frame_ok`, `crc_err`, `len_err` and `payload_len` hold until the next `frame_done`.
- The CRC is registered after each byte; the residue compare is combinational at the end edge.

## Test plan
- **Minimum unicast frame:** `local_mac`=00:1C:C0:A2:22:5D, 64-byte frame to that address with correct FCS. Required: 46 `out_valid`, `out_sop` on the first, `ethertype` correct, `frame_done` with `frame_ok`=1 and `payload_len`=46.
- **FCS error:** same frame with the last FCS byte bit 0 flipped. Required: 46 bytes forwarded, `crc_err`=1, `frame_ok`=0.
- **Broadcast filter:** dst FF:FF:FF:FF:FF:FF with `broadcast_en`=0. Required: no `out_valid` and no `frame_done`. With `broadcast_en`=1: frame accepted, `frame_ok`=1.
- **Length limits:** 1519-byte frame. Required: `out_valid` stops after byte 1518, `len_err`=1. 60-byte frame with valid CRC. Required: `len_err`=1, `crc_err`=0.
- **Back-to-back:** two valid frames separated by one `rx_active`=0 cycle. Required: both report `frame_ok`=1, and the second frame's `src_mac` updates only after the first frame's `frame_done`.
- **Reset mid-frame:** assert `reset_n`=0 at byte 20 and release at byte 30 of a 100-byte frame. Required: nothing reported for that frame, and the next valid frame is received with `frame_ok`=1.

Source files
------------

// File: rtl/eth_mac_recv.sv
// Receive MAC stage: destination filter, header extraction, FCS strip and
// end-of-frame CRC32/length status for an SFD-stripped byte stream.
module eth_mac_recv #(
    parameter int unsigned MIN_FRAME_LEN = 64,
    parameter int unsigned MAX_FRAME_LEN = 1518
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [47:0] local_mac,
    input  logic        broadcast_en,
    input  logic [7:0]  rx_data,
    input  logic        rx_active,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        out_sop,
    output logic [47:0] src_mac,
    output logic [15:0] ethertype,
    output logic        frame_done,
    output logic        frame_ok,
    output logic        crc_err,
    output logic        len_err,
    output logic [10:0] payload_len
);

    localparam logic [10:0] MinLen     = 11'(MIN_FRAME_LEN);
    localparam logic [10:0] MaxLen     = 11'(MAX_FRAME_LEN);
    localparam logic [31:0] CrcResidue = 32'hDEBB20E3;

    typedef enum logic [2:0] {
        StWaitIdle, StIdle, StDst, StSrc, StType, StPayload, StDrop
    } state_e;

    state_e      r_state;
    state_e      w_state_next;

    logic [10:0]      r_byte_cnt;
    logic [39:0]      r_dst;
    logic [31:0]      r_crc;
    logic [3:0][7:0]  r_pipe;
    logic [2:0]       r_pipe_cnt;
    logic [10:0]      r_pay_cnt;
    logic             r_accepted;

    logic [10:0] w_cnt_inc;
    logic [47:0] w_dst_full;
    logic        w_match;
    logic [31:0] w_crc_next;
    logic        w_over;
    logic        w_in_frame;
    logic        w_emit;
    logic        w_end;
    logic        w_len_bad;
    logic        w_crc_bad;

    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            c = (c[0] ^ data[i]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    assign w_cnt_inc  = (r_byte_cnt == 11'h7FF) ? r_byte_cnt : r_byte_cnt + 11'd1;
    assign w_dst_full = {r_dst, rx_data};
    assign w_match    = (w_dst_full == local_mac) || (broadcast_en && (&w_dst_full));
    // The first byte of a frame restarts the CRC from the all-ones seed.
    assign w_crc_next = crc_byte((r_state == StIdle) ? 32'hFFFFFFFF : r_crc, rx_data);
    assign w_over     = w_cnt_inc > MaxLen;
    assign w_in_frame = r_state inside {StDst, StSrc, StType, StPayload, StDrop};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StWaitIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StWaitIdle: if (!rx_active) w_state_next = StIdle;
            StIdle:     if (rx_active) w_state_next = StDst;
            StDst: begin
                if (!rx_active) begin
                    w_state_next = StIdle;
                end else if (r_byte_cnt == 11'd5) begin
                    w_state_next = w_match ? StSrc : StDrop;
                end
            end
            StSrc: begin
                if (!rx_active) begin
                    w_state_next = StIdle;
                end else if (r_byte_cnt == 11'd11) begin
                    w_state_next = StType;
                end
            end
            StType: begin
                if (!rx_active) begin
                    w_state_next = StIdle;
                end else if (r_byte_cnt == 11'd13) begin
                    w_state_next = StPayload;
                end
            end
            StPayload: begin
                if (!rx_active) begin
                    w_state_next = StIdle;
                end else if (w_over) begin
                    w_state_next = StDrop;
                end
            end
            StDrop:     if (!rx_active) w_state_next = StIdle;
            default:    w_state_next = StWaitIdle;
        endcase
    end

    always_comb begin
        w_emit    = (r_state == StPayload) && rx_active && !w_over && (r_pipe_cnt == 3'd4);
        w_end     = !rx_active && ((r_state inside {StSrc, StType, StPayload}) ||
                                   ((r_state == StDrop) && r_accepted));
        w_len_bad = (r_state inside {StSrc, StType}) || (r_byte_cnt < MinLen) ||
                    (r_byte_cnt > MaxLen);
        w_crc_bad = r_crc != CrcResidue;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_byte_cnt  <= '0;
            r_dst       <= '0;
            r_crc       <= '0;
            r_pipe      <= '0;
            r_pipe_cnt  <= '0;
            r_pay_cnt   <= '0;
            r_accepted  <= 1'b0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            out_sop     <= 1'b0;
            src_mac     <= '0;
            ethertype   <= '0;
            frame_done  <= 1'b0;
            frame_ok    <= 1'b0;
            crc_err     <= 1'b0;
            len_err     <= 1'b0;
            payload_len <= '0;
        end else begin
            if (rx_active && (r_state == StIdle)) begin
                r_byte_cnt <= 11'd1;
                r_dst      <= {r_dst[31:0], rx_data};
                r_crc      <= w_crc_next;
                r_pipe_cnt <= '0;
                r_pay_cnt  <= '0;
                r_accepted <= 1'b0;
            end else if (rx_active && w_in_frame) begin
                r_byte_cnt <= w_cnt_inc;
                r_crc      <= w_crc_next;
            end

            if (rx_active && (r_state == StDst)) begin
                r_dst <= {r_dst[31:0], rx_data};
                if ((r_byte_cnt == 11'd5) && w_match) r_accepted <= 1'b1;
            end
            if (rx_active && (r_state == StSrc)) src_mac <= {src_mac[39:0], rx_data};
            if (rx_active && (r_state == StType)) ethertype <= {ethertype[7:0], rx_data};

            // Four-byte delay line: the last four bytes (FCS) never leave it.
            if (rx_active && (r_state == StPayload) && !w_over) begin
                r_pipe     <= {r_pipe[2:0], rx_data};
                r_pipe_cnt <= (r_pipe_cnt == 3'd4) ? r_pipe_cnt : r_pipe_cnt + 3'd1;
            end

            out_valid <= w_emit;
            out_sop   <= w_emit && (r_pay_cnt == 11'd0);
            if (w_emit) begin
                out_data  <= r_pipe[3];
                r_pay_cnt <= r_pay_cnt + 11'd1;
            end

            frame_done <= w_end;
            if (w_end) begin
                crc_err     <= w_crc_bad;
                len_err     <= w_len_bad;
                frame_ok    <= !w_crc_bad && !w_len_bad;
                payload_len <= r_pay_cnt;
            end
        end
    end

endmodule

// File: tb/tb_eth_mac_recv.sv
// Scoreboard bench for eth_mac_recv: expected payload bytes and end-of-frame
// status are queued as frames are driven and compared as the DUT reports them.
module tb_eth_mac_recv;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [47:0] local_mac;
    logic        broadcast_en;
    logic [7:0]  rx_data;
    logic        rx_active;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_sop;
    logic [47:0] src_mac;
    logic [15:0] ethertype;
    logic        frame_done;
    logic        frame_ok;
    logic        crc_err;
    logic        len_err;
    logic [10:0] payload_len;

    eth_mac_recv #(
        .MIN_FRAME_LEN(64),
        .MAX_FRAME_LEN(1518)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .local_mac   (local_mac),
        .broadcast_en(broadcast_en),
        .rx_data     (rx_data),
        .rx_active   (rx_active),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_sop     (out_sop),
        .src_mac     (src_mac),
        .ethertype   (ethertype),
        .frame_done  (frame_done),
        .frame_ok    (frame_ok),
        .crc_err     (crc_err),
        .len_err     (len_err),
        .payload_len (payload_len)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          crc;
        bit          len;
        int          plen;
        bit          chk_crc;
        bit          chk_hdr;
        logic [47:0] src;
        logic [15:0] et;
    } status_t;

    int          n_total = 0;
    int          n_bad   = 0;
    int          n_done  = 0;
    int          exp_done = 0;
    logic [8:0]  exp_bytes[$];
    status_t     exp_stat[$];
    logic [7:0]  fq[$];

    localparam logic [47:0] MyMac = 48'h001CC0A2225D;
    localparam logic [47:0] Bcast = 48'hFFFFFFFFFFFF;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc ^ {24'd0, d};
        for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        return c;
    endfunction

    task automatic build(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] et,
                         input int n, input bit bad);
        logic [31:0] c;
        fq.delete();
        for (int i = 0; i < 6; i++) fq.push_back(dst[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) fq.push_back(src[47-8*i -: 8]);
        fq.push_back(et[15:8]);
        fq.push_back(et[7:0]);
        for (int i = 0; i < n; i++) fq.push_back(8'($urandom_range(0, 255)));
        c = 32'hFFFFFFFF;
        foreach (fq[i]) c = crc_step(c, fq[i]);
        c = ~c;
        fq.push_back(c[7:0]);
        fq.push_back(c[15:8]);
        fq.push_back(c[23:16]);
        fq.push_back(c[31:24] ^ {7'd0, bad});
    endtask

    // Byte b (1-based) received while in payload releases byte b-4, up to the max length.
    task automatic expect_frame(input logic [47:0] src, input logic [15:0] et, input bit bad,
                                input bit chk_crc);
        status_t s;
        int      len;
        int      last;
        len  = fq.size();
        last = (len > 1518) ? 1518 : len;
        for (int b = 19; b <= last; b++) exp_bytes.push_back({(b == 19), fq[b-5]});
        s.crc     = bad;
        s.len     = (len < 64) || (len > 1518);
        s.plen    = (last > 18) ? last - 18 : 0;
        s.chk_crc = chk_crc;
        s.chk_hdr = 1'b1;
        s.src     = src;
        s.et      = et;
        exp_stat.push_back(s);
        exp_done++;
    endtask

    task automatic send(input int gap);
        foreach (fq[i]) begin
            @(negedge clock);
            rx_active = 1'b1;
            rx_data   = fq[i];
        end
        @(negedge clock);
        rx_active = 1'b0;
        rx_data   = 8'h00;
        repeat (gap - 1) @(negedge clock);
    endtask

    always @(negedge clock) begin
        if (reset_n) begin
            if (out_valid) begin
                if (exp_bytes.size() == 0) begin
                    check("extra_valid", 64'(out_valid), 64'd0);
                end else begin
                    logic [8:0] e;
                    e = exp_bytes.pop_front();
                    check("data", 64'(out_data), 64'(e[7:0]));
                    check("sop", 64'(out_sop), 64'(e[8]));
                end
            end
            if (frame_done) begin
                n_done++;
                if (exp_stat.size() == 0) begin
                    check("extra_done", 64'(frame_done), 64'd0);
                end else begin
                    status_t s;
                    s = exp_stat.pop_front();
                    check("len_err", 64'(len_err), 64'(s.len));
                    check("payload_len", 64'(payload_len), 64'(s.plen));
                    if (s.chk_crc) begin
                        check("crc_err", 64'(crc_err), 64'(s.crc));
                        check("frame_ok", 64'(frame_ok), 64'(!s.crc && !s.len));
                    end else begin
                        check("frame_ok_bad", 64'(frame_ok), 64'd0);
                    end
                    if (s.chk_hdr) begin
                        check("src_mac", 64'(src_mac), 64'(s.src));
                        check("ethertype", 64'(ethertype), 64'(s.et));
                    end
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        status_t s;
        reset_n      = 1'b0;
        rx_active    = 1'b0;
        rx_data      = 8'h00;
        local_mac    = MyMac;
        broadcast_en = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_frame_done", 64'(frame_done), 64'd0);
        check("rst_src_mac", 64'(src_mac), 64'd0);
        check("rst_ethertype", 64'(ethertype), 64'd0);
        check("rst_payload_len", 64'(payload_len), 64'd0);
        check("rst_frame_ok", 64'(frame_ok), 64'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        // Minimum unicast frame, then the same with a corrupted FCS.
        build(MyMac, 48'h02AABBCCDDEE, 16'h0800, 46, 1'b0);
        expect_frame(48'h02AABBCCDDEE, 16'h0800, 1'b0, 1'b1);
        send(4);
        build(MyMac, 48'h02AABBCCDDEE, 16'h0800, 46, 1'b1);
        expect_frame(48'h02AABBCCDDEE, 16'h0800, 1'b1, 1'b1);
        send(4);

        // Broadcast rejected, then accepted.
        build(Bcast, 48'h021122334455, 16'h0806, 50, 1'b0);
        send(4);
        broadcast_en = 1'b1;
        build(Bcast, 48'h021122334455, 16'h0806, 50, 1'b0);
        expect_frame(48'h021122334455, 16'h0806, 1'b0, 1'b1);
        send(4);
        broadcast_en = 1'b0;

        // Foreign unicast is dropped.
        build(48'h001CC0A2225C, 48'h020000000001, 16'h0800, 60, 1'b0);
        send(4);

        // Oversize (1519) and undersize (60) frames.
        build(MyMac, 48'h02CAFE000001, 16'h86DD, 1501, 1'b0);
        expect_frame(48'h02CAFE000001, 16'h86DD, 1'b0, 1'b0);
        send(4);
        build(MyMac, 48'h02CAFE000002, 16'h0800, 42, 1'b0);
        expect_frame(48'h02CAFE000002, 16'h0800, 1'b0, 1'b1);
        send(4);

        // Truncated in SRC: reported with len_err and no payload.
        build(MyMac, 48'h02BEEF000001, 16'h0800, 46, 1'b0);
        fq = fq[0:9];
        s.crc = 1'b1; s.len = 1'b1; s.plen = 0; s.chk_crc = 1'b0; s.chk_hdr = 1'b0;
        s.src = '0; s.et = '0;
        exp_stat.push_back(s);
        exp_done++;
        send(4);

        // Back-to-back with a single idle cycle.
        build(MyMac, 48'h02000000AA01, 16'h0800, 60, 1'b0);
        expect_frame(48'h02000000AA01, 16'h0800, 1'b0, 1'b1);
        send(1);
        build(MyMac, 48'h02000000BB02, 16'h88B5, 70, 1'b0);
        expect_frame(48'h02000000BB02, 16'h88B5, 1'b0, 1'b1);
        send(4);

        // Reset asserted at byte 20, released at byte 30: frame must vanish.
        build(MyMac, 48'h02DEAD000001, 16'h0800, 82, 1'b0);
        foreach (fq[i]) begin
            @(negedge clock);
            rx_active = 1'b1;
            rx_data   = fq[i];
            if (i == 19) reset_n = 1'b0;
            if (i == 29) reset_n = 1'b1;
        end
        @(negedge clock);
        rx_active = 1'b0;
        repeat (3) @(negedge clock);
        build(MyMac, 48'h02DEAD000002, 16'h0800, 50, 1'b0);
        expect_frame(48'h02DEAD000002, 16'h0800, 1'b0, 1'b1);
        send(4);

        repeat (20) @(negedge clock);
        check("bytes_left", 64'(exp_bytes.size()), 64'd0);
        check("status_left", 64'(exp_stat.size()), 64'd0);
        check("done_count", 64'(n_done), 64'(exp_done));
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
